// File: rtl/axil_byte_master.sv
// ---------------------------------------------------------------------------
// axil_byte_master
//
// Bridges a byte stream (typically a UART receiver/transmitter pair) to an
// AXI4-Lite master port. Incoming command frames:
//   write: 0x57, A2, A1, A0, D1, D0
//   read : 0x52, A2, A1, A0
// Address is {A2,A1,A0} truncated to ADDR_WIDTH and data is {D1,D0}
// (big-endian). Each command yields a response on the output stream:
//   write: {6'b0, bresp}
//   read : {6'b0, rresp}, rdata[15:8], rdata[7:0]
// Bytes that arrive in IDLE and are not a command byte are discarded.
// Only one AXI transaction is ever in flight.
//
// Handshakes: a byte-stream or AXI transfer completes on a rising edge
// where valid and ready are both high. Once a valid is raised by this
// block, it stays high with a stable payload until the matching ready.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   in_t*                  command byte stream (sink)
//   out_t*                 response byte stream (source)
//   m_axil_aw*/w*/b*       AXI4-Lite write channels
//   m_axil_ar*/r*          AXI4-Lite read channels
//   busy                   high whenever the FSM is not in IDLE
//
// ADDR_WIDTH legal range is 1..24; DATA_WIDTH must be 16.
// ---------------------------------------------------------------------------
module axil_byte_master #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic [7:0]              in_tdata,
    input  logic                    in_tvalid,
    output logic                    in_tready,

    output logic [7:0]              out_tdata,
    output logic                    out_tvalid,
    input  logic                    out_tready,

    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [1:0]              m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,

    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready,

    output logic                    busy
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        WR_REQ   = 3'd3,
        WR_RESP  = 3'd4,
        RD_REQ   = 3'd5,
        RD_RESP  = 3'd6,
        SEND     = 3'd7
    } state_t;

    state_t                  state_q,    state_d;
    logic                    is_write_q, is_write_d;
    logic [1:0]              cnt_q,      cnt_d;      // byte counter, reused per phase
    logic [1:0]              len_q,      len_d;      // response length in bytes
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q,    rdata_d;
    logic [7:0]              out_q,      out_d;
    logic                    awvalid_q,  awvalid_d;
    logic                    wvalid_q,   wvalid_d;

    logic in_fire;
    logic out_fire;

    assign in_tready  = (state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA);
    assign in_fire    = in_tvalid && in_tready;
    assign out_tvalid = (state_q == SEND);
    assign out_fire   = out_tvalid && out_tready;
    assign out_tdata  = out_q;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_wstrb   = 2'b11;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = (state_q == WR_RESP);
    assign m_axil_arvalid = (state_q == RD_REQ);
    assign m_axil_rready  = (state_q == RD_RESP);
    assign busy           = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        out_d      = out_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    if (in_tdata == CMD_WRITE) begin
                        is_write_d = 1'b1;
                        cnt_d      = 2'd0;
                        state_d    = GET_ADDR;
                    end else if (in_tdata == CMD_READ) begin
                        is_write_d = 1'b0;
                        cnt_d      = 2'd0;
                        state_d    = GET_ADDR;
                    end
                end
            end

            GET_ADDR: begin
                if (in_fire) begin
                    // Shift in big-endian; the cast keeps the low ADDR_WIDTH bits.
                    addr_d = ADDR_WIDTH'({addr_q, in_tdata});
                    if (cnt_q == 2'd2) begin
                        cnt_d   = 2'd0;
                        state_d = is_write_q ? GET_DATA : RD_REQ;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            GET_DATA: begin
                if (in_fire) begin
                    wdata_d = {wdata_q[7:0], in_tdata};
                    if (cnt_q == 2'd1) begin
                        cnt_d     = 2'd0;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            WR_REQ: begin
                // AW and W retire independently; leave once neither is pending.
                if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
                    state_d = WR_RESP;
                end
            end

            WR_RESP: begin
                if (m_axil_bvalid) begin
                    out_d   = {6'b0, m_axil_bresp};
                    len_d   = 2'd1;
                    cnt_d   = 2'd0;
                    state_d = SEND;
                end
            end

            RD_REQ: begin
                if (m_axil_arready) state_d = RD_RESP;
            end

            RD_RESP: begin
                if (m_axil_rvalid) begin
                    out_d   = {6'b0, m_axil_rresp};
                    rdata_d = m_axil_rdata;
                    len_d   = 2'd3;
                    cnt_d   = 2'd0;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (out_fire) begin
                    if (cnt_q == len_q - 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        out_d = (cnt_q == 2'd0) ? rdata_q[15:8] : rdata_q[7:0];
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            cnt_q      <= 2'd0;
            len_q      <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            out_q      <= 8'h00;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            out_q      <= out_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
        end
    end

endmodule

// File: tb/tb_axil_byte_master.sv
// ---------------------------------------------------------------------------
// tb_axil_byte_master
//
// Directed bench for axil_byte_master (ADDR_WIDTH=18). Inputs are driven
// and outputs sampled on the falling clock edge; the DUT acts on the
// rising edge. Each scenario task drives its own stimulus and checks its
// own hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_axil_byte_master;

    localparam int AW = 18;

    logic          clk;
    logic          resetn;
    logic [7:0]    in_tdata;
    logic          in_tvalid;
    logic          in_tready;
    logic [7:0]    out_tdata;
    logic          out_tvalid;
    logic          out_tready;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [15:0]   wdata;
    logic [1:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [15:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic          busy;

    int total = 0;
    int bad   = 0;

    axil_byte_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_tdata       (in_tdata),
        .in_tvalid      (in_tvalid),
        .in_tready      (in_tready),
        .out_tdata      (out_tdata),
        .out_tvalid     (out_tvalid),
        .out_tready     (out_tready),
        .m_axil_awaddr  (awaddr),
        .m_axil_awprot  (awprot),
        .m_axil_awvalid (awvalid),
        .m_axil_awready (awready),
        .m_axil_wdata   (wdata),
        .m_axil_wstrb   (wstrb),
        .m_axil_wvalid  (wvalid),
        .m_axil_wready  (wready),
        .m_axil_bresp   (bresp),
        .m_axil_bvalid  (bvalid),
        .m_axil_bready  (bready),
        .m_axil_araddr  (araddr),
        .m_axil_arprot  (arprot),
        .m_axil_arvalid (arvalid),
        .m_axil_arready (arready),
        .m_axil_rdata   (rdata),
        .m_axil_rresp   (rresp),
        .m_axil_rvalid  (rvalid),
        .m_axil_rready  (rready),
        .busy           (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a scenario wedges outside a bounded wait.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Present one byte; returns on the falling edge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_tdata  = b;
        in_tvalid = 1'b1;
        while (!in_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_tready) begin
            total++;
            bad++;
            $display("FAIL send_byte_timeout: in_tready=%0b required 1 for byte %h", in_tready, b);
        end
        @(negedge clk);
        in_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[], input int len);
        for (int i = 0; i < len; i++) send_byte(f[i]);
    endtask

    // Accept one response byte and compare it.
    task automatic recv_byte(input logic [7:0] exp, input string name);
        int n;
        n = 0;
        out_tready = 1'b1;
        while (!out_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!out_tvalid) begin
            bad++;
            $display("FAIL %s: out_tvalid=0 after %0d cycles, required byte %h", name, n, exp);
        end else if (out_tdata !== exp) begin
            bad++;
            $display("FAIL %s: out_tdata=%h required %h", name, out_tdata, exp);
        end
        @(negedge clk);
        out_tready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        total++;
        if (in_tready !== 1'b1 || busy !== 1'b0 || out_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: in_tready=%b busy=%b out_tvalid=%b required 1 0 0",
                     in_tready, busy, out_tvalid);
        end
        total++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_axi_valid: aw/w/b/ar/r=%b required 00000",
                     {awvalid, wvalid, bready, arvalid, rready});
        end
        total++;
        if (awaddr !== '0 || araddr !== '0 || wdata !== 16'h0 || out_tdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_regs: awaddr=%h araddr=%h wdata=%h out_tdata=%h required 0",
                     awaddr, araddr, wdata, out_tdata);
        end
        total++;
        if (awprot !== 3'b000 || arprot !== 3'b000 || wstrb !== 2'b11) begin
            bad++;
            $display("FAIL reset_consts: awprot=%b arprot=%b wstrb=%b required 000 000 11",
                     awprot, arprot, wstrb);
        end
    endtask

    task automatic test_write();
        logic [7:0] f[];
        f = '{8'h57, 8'h00, 8'h12, 8'h34, 8'hBE, 8'hEF};
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        send_frame(f, 6);
        total++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 18'h01234 || wdata !== 16'hBEEF
            || wstrb !== 2'b11) begin
            bad++;
            $display("FAIL write_req: awv=%b wv=%b awaddr=%h wdata=%h wstrb=%b required 1 1 01234 beef 11",
                     awvalid, wvalid, awaddr, wdata, wstrb);
        end
        recv_byte(8'h00, "write_status");
        bvalid = 1'b0;
        total++;
        if (busy !== 1'b0 || out_tvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
            bad++;
            $display("FAIL write_done: busy=%b out_tvalid=%b awv=%b wv=%b required 0 0 0 0",
                     busy, out_tvalid, awvalid, wvalid);
        end
    endtask

    task automatic test_read();
        logic [7:0] f[];
        f = '{8'h52, 8'h03, 8'hFF, 8'hFE};
        arready = 1'b1;
        send_frame(f, 4);
        total++;
        if (arvalid !== 1'b1 || araddr !== 18'h3FFFE || awvalid !== 1'b0) begin
            bad++;
            $display("FAIL read_req: arvalid=%b araddr=%h awvalid=%b required 1 3fffe 0",
                     arvalid, araddr, awvalid);
        end
        rvalid = 1'b1; rdata = 16'hA55A; rresp = 2'b00;
        @(negedge clk);
        total++;
        if (rready !== 1'b1 || arvalid !== 1'b0) begin
            bad++;
            $display("FAIL read_rready: rready=%b arvalid=%b required 1 0", rready, arvalid);
        end
        recv_byte(8'h00, "read_status");
        rvalid = 1'b0;
        recv_byte(8'hA5, "read_hi");
        recv_byte(8'h5A, "read_lo");
        total++;
        if (busy !== 1'b0 || out_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL read_done: busy=%b out_tvalid=%b required 0 0", busy, out_tvalid);
        end
    endtask

    task automatic test_skewed_write();
        logic [7:0] f[];
        f = '{8'h57, 8'h00, 8'h00, 8'h40, 8'h12, 8'h34};
        awready = 1'b0; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
        send_frame(f, 6);
        // Cycle 1 of awvalid: both valids up, W handshakes on the next edge.
        total++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || bready !== 1'b0) begin
            bad++;
            $display("FAIL skew_c1: awv=%b wv=%b bready=%b required 1 1 0", awvalid, wvalid, bready);
        end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) awready = 1'b1;
            total++;
            if (awvalid !== 1'b1 || wvalid !== 1'b0 || bready !== 1'b0) begin
                bad++;
                $display("FAIL skew_c%0d: awv=%b wv=%b bready=%b required 1 0 0",
                         c, awvalid, wvalid, bready);
            end
        end
        @(negedge clk);
        awready = 1'b0;
        total++;
        if (awvalid !== 1'b0 || bready !== 1'b1 || awaddr !== 18'h00040 || wdata !== 16'h1234) begin
            bad++;
            $display("FAIL skew_after: awv=%b bready=%b awaddr=%h wdata=%h required 0 1 00040 1234",
                     awvalid, bready, awaddr, wdata);
        end
        bvalid = 1'b1;
        recv_byte(8'h00, "skew_status");
        bvalid = 1'b0;
    endtask

    task automatic test_error_backpressure();
        logic [7:0] f[];
        int n;
        f = '{8'h57, 8'h01, 8'h00, 8'h02, 8'h55, 8'hAA};
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        out_tready = 1'b0;
        send_frame(f, 6);
        n = 0;
        while (!out_tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        bvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (out_tvalid !== 1'b1 || out_tdata !== 8'h02 || in_tready !== 1'b0) begin
                bad++;
                $display("FAIL err_hold%0d: out_tvalid=%b out_tdata=%h in_tready=%b required 1 02 0",
                         c, out_tvalid, out_tdata, in_tready);
            end
            @(negedge clk);
        end
        recv_byte(8'h02, "err_status");
        total++;
        if (in_tready !== 1'b1 || out_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL err_done: in_tready=%b out_tvalid=%b required 1 0", in_tready, out_tvalid);
        end
        awready = 1'b0; wready = 1'b0; bresp = 2'b00;
    endtask

    task automatic test_garbage();
        arready = 1'b1;
        send_byte(8'h41);
        send_byte(8'h00);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL garbage_discard: busy=%b required 0", busy);
        end
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        total++;
        if (arvalid !== 1'b1 || araddr !== 18'h00010) begin
            bad++;
            $display("FAIL garbage_read: arvalid=%b araddr=%h required 1 00010", arvalid, araddr);
        end
        rvalid = 1'b1; rdata = 16'h1234; rresp = 2'b00;
        recv_byte(8'h00, "garbage_status");
        rvalid = 1'b0;
        recv_byte(8'h12, "garbage_hi");
        recv_byte(8'h34, "garbage_lo");
    endtask

    task automatic test_reset_mid();
        logic [7:0] f[];
        logic [7:0] g[];
        logic       seen;
        f = '{8'h52, 8'h00, 8'h00, 8'h20};
        g = '{8'h57, 8'h00, 8'h00, 8'h08, 8'hCA, 8'hFE};
        arready = 1'b1; rvalid = 1'b0;
        send_frame(f, 4);
        @(negedge clk);
        total++;
        if (rready !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: rready=%b busy=%b required 1 1", rready, busy);
        end
        #2 resetn = 1'b0;
        #1;
        total++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || busy !== 1'b0 || in_tready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_async: arvalid=%b rready=%b busy=%b in_tready=%b required 0 0 0 1",
                     arvalid, rready, busy, in_tready);
        end
        // A late rvalid must not produce any response after release.
        rvalid = 1'b1; rdata = 16'hFFFF; rresp = 2'b11;
        out_tready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_tvalid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_no_out: out_tvalid seen=%b required 0", seen);
        end
        out_tready = 1'b0;
        rvalid = 1'b0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        send_frame(g, 6);
        total++;
        if (awaddr !== 18'h00008 || wdata !== 16'hCAFE || awvalid !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_write: awaddr=%h wdata=%h awvalid=%b required 00008 cafe 1",
                     awaddr, wdata, awvalid);
        end
        recv_byte(8'h00, "rst_mid_status");
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        resetn = 1'b0;
        in_tdata = 8'h00; in_tvalid = 1'b0; out_tready = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        arready = 1'b0; rdata = 16'h0; rresp = 2'b00; rvalid = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        test_write();
        test_read();
        test_skewed_write();
        test_error_backpressure();
        test_garbage();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
